// File: rtl/dut_stim_harness.sv
// Stimulus/check harness: sequences a DUT reset, drives a counter or LFSR vector stream,
// and scores DUT responses against a golden value delayed by the DUT latency.
module dut_stim_harness #(
    parameter int               DATA_W      = 8,
    parameter int               RST_CYCLES  = 100,
    parameter int               LATENCY     = 1,
    parameter int               NUM_VECTORS = 256,
    parameter int               PATTERN     = 0,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(1),
    parameter logic [DATA_W-1:0] TAPS       = DATA_W'(8'hB8),
    parameter int               ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              dut_reset,
    output logic [DATA_W-1:0] dut_data_in,
    input  logic [DATA_W-1:0] dut_data_out,
    input  logic [DATA_W-1:0] ref_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [15:0]       first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0]       RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]       LAT_LAST  = 16'(LATENCY - 1);
    localparam logic [16:0]       VEC_TOTAL = 17'(NUM_VECTORS);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam logic [DATA_W-1:0] GEN_INIT  = (PATTERN == 0) ? '0 : SEED;

    state_t            state;
    state_t            next_state;
    logic [15:0]       phase_cnt;
    logic [16:0]       vec_cnt;
    logic [DATA_W-1:0] gen;
    logic [DATA_W-1:0] gen_next;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] ref_pipe [LATENCY];
    logic [LATENCY-1:0] vld_pipe;
    logic [15:0]       cmp_idx;
    logic              launch;
    logic              load_vec;
    logic              push;
    logic              cmp_vld;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) next_state = S_RESET;
            S_RESET:        if (phase_cnt == RST_LAST) next_state = S_RUN;
            S_RUN:          if (vec_cnt == VEC_TOTAL) next_state = S_DRAIN;
            S_DRAIN:        if (phase_cnt == LAT_LAST) next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end

    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
    // Vector 0 is loaded on the final RESET edge so RUN cycle k always shows vector k.
    assign load_vec  = ((state == S_RESET) && (phase_cnt == RST_LAST)) ||
                       ((state == S_RUN) && (vec_cnt != VEC_TOTAL));
    assign push      = (state == S_RUN);
    assign lfsr_next = (gen >> 1) ^ (gen[0] ? TAPS : '0);
    assign gen_next  = (PATTERN == 0) ? gen + DATA_W'(1) : lfsr_next;
    assign cmp_vld   = vld_pipe[LATENCY-1];
    assign mismatch  = cmp_vld && (ref_pipe[LATENCY-1] != dut_data_out);

    assign dut_reset = (state == S_IDLE) || (state == S_RESET);
    assign busy      = (state == S_RESET) || (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_cnt     <= '0;
            vec_cnt       <= '0;
            gen           <= GEN_INIT;
            dut_data_in   <= '0;
            vld_pipe      <= '0;
            cmp_idx       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            if (state != next_state) begin
                phase_cnt <= '0;
            end else if ((state == S_RESET) || (state == S_DRAIN)) begin
                phase_cnt <= phase_cnt + 16'd1;
            end

            if (launch) begin
                vec_cnt       <= '0;
                gen           <= GEN_INIT;
                vld_pipe      <= '0;
                cmp_idx       <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
            end else begin
                if (load_vec) begin
                    dut_data_in <= gen;
                    gen         <= gen_next;
                    vec_cnt     <= vec_cnt + 17'd1;
                end
                vld_pipe[0] <= push;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                end
                if (cmp_vld) begin
                    cmp_idx <= cmp_idx + 16'd1;
                end
                // Once saturated, further mismatches change nothing.
                if (mismatch && (err_count != ERR_MAX)) begin
                    err_count <= err_count + ERR_W'(1);
                    if (err_count == '0) begin
                        first_err_idx <= cmp_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        ref_pipe[0] <= ref_data;
        for (int i = 1; i < LATENCY; i++) begin
            ref_pipe[i] <= ref_pipe[i-1];
        end
    end

endmodule

// File: tb/tb_dut_stim_harness.sv
// Directed bench: three harness instances (counter, LFSR, saturating errors) each driving a
// small behavioural DUT model; expected values are hand-derived edge by edge.
module tb_dut_stim_harness;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic       flip = 1'b0;
    int         nvec = 0;
    int         nerr = 0;

    logic       dr0, busy0, done0, pass0;
    logic [7:0] in0, out0, m0_d1, m0_d2;
    logic [15:0] err0, first0;

    logic       dr1, busy1, done1, pass1;
    logic [7:0] in1, out1, m1_d1;
    logic [15:0] err1, first1;

    logic       dr2, busy2, done2, pass2;
    logic [7:0] in2, out2, m2_d1;
    logic [3:0] err2;
    logic [15:0] first2;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m0_d1 <= in0;
        m0_d2 <= m0_d1;
        m1_d1 <= in1;
        m2_d1 <= in2;
    end
    assign out0 = m0_d2 ^ {7'b0, flip && ((m0_d2 == 8'd5) || (m0_d2 == 8'd9))};
    assign out1 = m1_d1;
    assign out2 = m2_d1 ^ 8'hFF;

    dut_stim_harness #(.DATA_W(8), .RST_CYCLES(4), .LATENCY(2), .NUM_VECTORS(16),
                       .PATTERN(0), .ERR_W(16)) u0 (
        .clk(clk), .reset(reset), .start(start0), .dut_reset(dr0), .dut_data_in(in0),
        .dut_data_out(out0), .ref_data(in0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_idx(first0));

    dut_stim_harness #(.DATA_W(8), .RST_CYCLES(2), .LATENCY(1), .NUM_VECTORS(8),
                       .PATTERN(1), .SEED(8'h01), .TAPS(8'hB8), .ERR_W(16)) u1 (
        .clk(clk), .reset(reset), .start(start1), .dut_reset(dr1), .dut_data_in(in1),
        .dut_data_out(out1), .ref_data(in1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(first1));

    dut_stim_harness #(.DATA_W(8), .RST_CYCLES(2), .LATENCY(1), .NUM_VECTORS(20),
                       .PATTERN(0), .ERR_W(4)) u2 (
        .clk(clk), .reset(reset), .start(start2), .dut_reset(dr2), .dut_data_in(in2),
        .dut_data_out(out2), .ref_data(in2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(first2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start0 and returns the index of the edge at which done0 rose (E0 = start edge), -1 on timeout.
    task automatic run_u0(output int e);
        e = -1;
        start0 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            start0 = 1'b0;
            if (done0) begin
                e = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        nvec++; if (dr0 !== 1'b1)   begin nerr++; $display("FAIL reset_dut_reset: got %0b want 1", dr0); end
        nvec++; if (in0 !== 8'h00)  begin nerr++; $display("FAIL reset_data_in: got %0h want 0", in0); end
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %0b want 0", busy0); end
        nvec++; if (done0 !== 1'b0) begin nerr++; $display("FAIL reset_done: got %0b want 0", done0); end
        nvec++; if (pass0 !== 1'b0) begin nerr++; $display("FAIL reset_pass: got %0b want 0", pass0); end
        nvec++; if (err0 !== 16'd0) begin nerr++; $display("FAIL reset_err: got %0d want 0", err0); end
        nvec++; if (first0 !== 16'd0) begin nerr++; $display("FAIL reset_first: got %0d want 0", first0); end
        nvec++; if (in1 !== 8'h00)  begin nerr++; $display("FAIL reset_lfsr_data_in: got %0h want 0", in1); end
        reset = 1'b1;
        tick();
        nvec++; if (dr0 !== 1'b1 || busy0 !== 1'b0) begin nerr++; $display("FAIL idle_outputs: got dut_reset=%0b busy=%0b want 1 0", dr0, busy0); end
    endtask

    task automatic test_counter_pass();
        logic [7:0] exp_d;
        start0 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            start0 = 1'b0;
            nvec++; if (dr0 !== (i < 4))    begin nerr++; $display("FAIL cnt_dut_reset e%0d: got %0b want %0b", i, dr0, i < 4); end
            nvec++; if (busy0 !== (i < 22)) begin nerr++; $display("FAIL cnt_busy e%0d: got %0b want %0b", i, busy0, i < 22); end
            nvec++; if (done0 !== (i >= 22)) begin nerr++; $display("FAIL cnt_done e%0d: got %0b want %0b", i, done0, i >= 22); end
            nvec++; if (pass0 !== (i >= 22)) begin nerr++; $display("FAIL cnt_pass e%0d: got %0b want %0b", i, pass0, i >= 22); end
            if (i >= 4) begin
                exp_d = (i - 4 > 15) ? 8'h0F : 8'(i - 4);
                nvec++; if (in0 !== exp_d) begin nerr++; $display("FAIL cnt_data_in e%0d: got %0h want %0h", i, in0, exp_d); end
            end
        end
        nvec++; if (err0 !== 16'd0) begin nerr++; $display("FAIL cnt_err: got %0d want 0", err0); end
    endtask

    task automatic test_mismatch();
        int e;
        flip = 1'b1;
        run_u0(e);
        flip = 1'b0;
        nvec++; if (e !== 22)         begin nerr++; $display("FAIL mm_done_edge: got %0d want 22", e); end
        nvec++; if (err0 !== 16'd2)   begin nerr++; $display("FAIL mm_err: got %0d want 2", err0); end
        nvec++; if (first0 !== 16'd5) begin nerr++; $display("FAIL mm_first: got %0d want 5", first0); end
        nvec++; if (pass0 !== 1'b0)   begin nerr++; $display("FAIL mm_pass: got %0b want 0", pass0); end
    endtask

    task automatic test_start_in_run_and_done();
        int e;
        e = -1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        nvec++; if (done0 !== 1'b0)  begin nerr++; $display("FAIL restart_done: got %0b want 0", done0); end
        nvec++; if (err0 !== 16'd0)  begin nerr++; $display("FAIL restart_err: got %0d want 0", err0); end
        nvec++; if (busy0 !== 1'b1)  begin nerr++; $display("FAIL restart_busy: got %0b want 1", busy0); end
        for (int i = 1; i < 200; i++) begin
            if (i == 10) start0 = 1'b1;
            tick();
            start0 = 1'b0;
            if (done0) begin
                e = i;
                break;
            end
        end
        nvec++; if (e !== 22)       begin nerr++; $display("FAIL run_start_done_edge: got %0d want 22", e); end
        nvec++; if (pass0 !== 1'b1) begin nerr++; $display("FAIL run_start_pass: got %0b want 1", pass0); end
    endtask

    task automatic test_reset_midrun();
        int e;
        start0 = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            tick();
            start0 = 1'b0;
        end
        nvec++; if (in0 !== 8'h07) begin nerr++; $display("FAIL mid_vec7: got %0h want 07", in0); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        nvec++; if (dr0 !== 1'b1)   begin nerr++; $display("FAIL mid_dut_reset: got %0b want 1", dr0); end
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %0b want 0", busy0); end
        nvec++; if (err0 !== 16'd0) begin nerr++; $display("FAIL mid_err: got %0d want 0", err0); end
        nvec++; if (in0 !== 8'h00)  begin nerr++; $display("FAIL mid_data_in: got %0h want 0", in0); end
        run_u0(e);
        nvec++; if (e !== 22)       begin nerr++; $display("FAIL mid_rerun_done_edge: got %0d want 22", e); end
        nvec++; if (pass0 !== 1'b1) begin nerr++; $display("FAIL mid_rerun_pass: got %0b want 1", pass0); end
    endtask

    task automatic test_lfsr();
        logic [7:0] seq [6];
        int e;
        seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        e = -1;
        start1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            start1 = 1'b0;
            if (i >= 2 && i <= 7) begin
                nvec++; if (in1 !== seq[i-2]) begin nerr++; $display("FAIL lfsr_vec%0d: got %0h want %0h", i - 2, in1, seq[i-2]); end
            end
            if (done1) begin
                e = i;
                break;
            end
        end
        nvec++; if (e !== 11)       begin nerr++; $display("FAIL lfsr_done_edge: got %0d want 11", e); end
        nvec++; if (pass1 !== 1'b1) begin nerr++; $display("FAIL lfsr_pass: got %0b want 1", pass1); end
    endtask

    task automatic test_saturation();
        int e;
        e = -1;
        start2 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            start2 = 1'b0;
            if (done2) begin
                e = i;
                break;
            end
        end
        nvec++; if (e !== 23)         begin nerr++; $display("FAIL sat_done_edge: got %0d want 23", e); end
        nvec++; if (err2 !== 4'd15)   begin nerr++; $display("FAIL sat_err: got %0d want 15", err2); end
        nvec++; if (first2 !== 16'd0) begin nerr++; $display("FAIL sat_first: got %0d want 0", first2); end
        nvec++; if (pass2 !== 1'b0)   begin nerr++; $display("FAIL sat_pass: got %0b want 0", pass2); end
        nvec++; if (busy2 !== 1'b0 || dr2 !== 1'b0) begin nerr++; $display("FAIL sat_done_outputs: got busy=%0b dut_reset=%0b want 0 0", busy2, dr2); end
    endtask

    initial begin
        test_reset();
        test_counter_pass();
        test_mismatch();
        test_start_in_run_and_done();
        test_reset_midrun();
        test_lfsr();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dut_stim_harness.md
# dut_stim_harness

Parametrised, synthesizable stimulus and checking harness that sits between the bench clock/reset and a `top_level_*` DUT. It sequences the DUT reset for a programmable hold time and drives a counter or LFSR vector stream into the DUT. It compares the DUT output against a golden-model value delayed by the DUT pipeline latency, and reports error count, first failing vector and pass/fail. It replaces hand-written reset/clock initial blocks so the same harness runs in simulation and on FPGA.

## Interface
- `DATA_W`, 8: width of DUT data in/out.
- `RST_CYCLES`, 100: cycles the DUT reset is held high after start; range 1..2^16-1.
- `LATENCY`, 1: DUT pipeline depth in cycles; range 1..16.
- `NUM_VECTORS`, 256: vectors per run; range 1..2^16.
- `PATTERN`, 0: 0 = incrementing counter from 0; 1 = Galois LFSR.
- `SEED`, 1: LFSR initial value; must be nonzero.
- `TAPS`, 8'hB8: LFSR feedback mask, DATA_W bits.
- `ERR_W`, 16: error counter width.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low harness reset.
- `start` in 1: begin a run; sampled in IDLE and DONE only.
- `dut_reset` out 1: active-high DUT reset.
- `dut_data_in` out DATA_W: registered stimulus vector.
- `dut_data_out` in DATA_W: DUT response.
- `ref_data` in DATA_W: golden-model output for the current `dut_data_in`, computed combinationally outside the harness.
- `busy` out 1: high in RESET, RUN, DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: `done` && `err_count`==0.
- `err_count` out ERR_W: mismatches, saturating.
- `first_err_idx` out 16: index of the first mismatching vector. Valid when `err_count`≠0.

## Operation
- FSM states: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE: `start`=1 → RESET. Clears `err_count`, `first_err_idx`, vector counter, pattern generator and valid pipe.
- RESET: `dut_reset`=1 for exactly RST_CYCLES cycles → RUN.
- RUN: `dut_reset`=0. Drives one vector per cycle, vector k in RUN cycle k (k=0..NUM_VECTORS-1). Exits to DRAIN after vector NUM_VECTORS-1.
- DRAIN: lasts LATENCY cycles → DONE. `dut_data_in` holds the last vector.
- DONE: outputs hold. `start`=1 → RESET, with the same clearing as IDLE→RESET.
- `start` in RESET, RUN or DRAIN is ignored.
- Counter pattern: vector k = k mod 2^DATA_W.
- LFSR pattern: vector 0 = SEED. Next value = (v>>1) ^ (v[0] ? TAPS : 0).
- Checker:
  - `ref_data` and a valid bit enter a LATENCY-deep delay line every RUN cycle.
  - When a valid entry emerges, it is compared with `dut_data_out`.
  - On mismatch, `err_count` increments, saturating at 2^ERR_W-1.
  - On the first mismatch, `first_err_idx` is set to that vector's index.
- Reset values (`reset`=0 on any edge, in any state):
  - State → IDLE.
  - `dut_reset`=1, `dut_data_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0.
  - Delay-line valid bits are cleared.

## Timing
- Edge E0 samples `start`. RESET occupies the cycles after E0..E(RST_CYCLES-1).
- RUN cycle k follows edge E(RST_CYCLES+k).
- Vector k is compared at the end of RUN cycle k+LATENCY (counting continues into DRAIN).
- `done` rises after edge E(RST_CYCLES+NUM_VECTORS+LATENCY). It is visible together with the final `err_count` update.
- `busy` and `done` are never both high. `pass` is never high outside DONE.
- Mismatch on the saturating cycle: `err_count` stays at max, and `first_err_idx` is unaffected.

## Test plan
- DATA_W=8, RST_CYCLES=4, LATENCY=2, NUM_VECTORS=16, PATTERN=0. DUT model = 2-stage delay, `ref_data`=`dut_data_in`. Pulse `start` → `dut_reset` high 4 cycles, vectors 0x00..0x0F, `done` after E22, `pass`=1, `err_count`=0.
- Same setup, DUT model flips bit0 on vectors 5 and 9 → `err_count`=2, `first_err_idx`=5, `pass`=0.
- PATTERN=1, SEED=0x01, TAPS=0xB8 → `dut_data_in` sequence 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
- Drive `reset` low during RUN at vector 7 → next edge: IDLE, `dut_reset`=1, `busy`=0, `err_count`=0. A fresh `start` completes with `pass`=1.
- `start` pulsed in RUN → no effect, `done` at the same edge as without it. `start` in DONE → `done`=0, `err_count` cleared, run repeats.
- ERR_W=4, NUM_VECTORS=20, every vector mismatching → `err_count`=15, `first_err_idx`=0.
